// File: rtl/score_pkg.sv
// Shared state encoding and BCD constants for the score display path.
// Imported by score_ctrl and bcd_add_sat.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FLASH  = 2'd2,
    ST_REVIEW = 2'd3
  } state_e;

  localparam logic [7:0] BCD_MAX = 8'h99;
  localparam logic [3:0] PTS_DEF = 4'd1;

endpackage

// File: rtl/bcd_add_sat.sv
// Two-digit BCD adder with a single-digit addend.
// The sum saturates at 99 instead of wrapping.
module bcd_add_sat
  import score_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] sum_o
);

  logic [4:0] ones_raw;
  logic       carry;
  logic [3:0] ones_adj;
  logic [4:0] tens;

  assign ones_raw = {1'b0, a_i[3:0]} + {1'b0, b_i};
  assign carry    = ones_raw > 5'd9;
  assign ones_adj = carry ? 4'(ones_raw - 5'd10)
                          : ones_raw[3:0];
  assign tens     = {1'b0, a_i[7:4]} + {4'b0, carry};
  assign sum_o    = (tens > 5'd9) ? BCD_MAX
                                  : {tens[3:0], ones_adj};

endmodule

// File: rtl/score_ctrl.sv
// Score/high-score keeper and display sequencer for the 7-seg path.
// SCORE_HIGH_EN enables the high-score register and REVIEW alternation.
module score_ctrl
  import score_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_CNT = 6,
  parameter int ALT_TICKS = 4,
  parameter int BONUS_PTS = 5
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_start,
  input  logic       I_eat,
  input  logic       I_bonus,
  input  logic       I_game_over,
  output logic [7:0] O_score,
  output logic       O_blank,
  output logic [7:0] O_high,
  output logic [1:0] O_state
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [4:0] FLASH_END = 5'(2 * BLINK_CNT);
  localparam logic [4:0] ALT_END   = 5'(ALT_TICKS);
  localparam logic [3:0] BONUS     = 4'(BONUS_PTS);

`ifdef SCORE_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    high_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    ph_q, ph_d;
  logic          blank_q, blank_d;
  logic          alt_q, alt_d;
  logic [7:0]    o_score_q, o_score_d;
  logic          o_blank_q;
  logic [7:0]    o_high_q;
  logic [1:0]    o_state_q;

  logic [3:0] addend;
  logic [7:0] score_inc;
  logic       tick;

  assign addend = I_bonus ? BONUS : PTS_DEF;
  assign tick   = cnt_q == CNT_MAX;

  bcd_add_sat u_add (
    .a_i  (score_q),
    .b_i  (addend),
    .sum_o(score_inc)
  );

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    blank_d = blank_q;
    alt_d   = alt_q;
    ph_d    = ph_q;
    if (I_start) begin
      state_d = ST_PLAY;
      score_d = '0;
      blank_d = 1'b0;
      alt_d   = 1'b0;
      ph_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_PLAY: begin
          if (I_eat) score_d = score_inc;
          if (I_game_over) begin
            state_d = ST_FLASH;
            blank_d = 1'b0;
            ph_d    = '0;
          end
        end
        ST_FLASH: begin
          if (tick) begin
            if (ph_q + 5'd1 == FLASH_END) begin
              state_d = ST_REVIEW;
              blank_d = 1'b0;
              alt_d   = 1'b0;
              ph_d    = '0;
            end else begin
              blank_d = ~blank_q;
              ph_d    = ph_q + 5'd1;
            end
          end
        end
        ST_REVIEW: begin
          if (tick) begin
            if (ph_q + 5'd1 == ALT_END) begin
              ph_d  = '0;
              alt_d = ~alt_q;
            end else begin
              ph_d = ph_q + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tick phase restarts on every state change
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q || tick) cnt_d = '0;
  end

  always_comb begin
    o_score_d = score_q;
    unique case (state_q)
      ST_IDLE:   o_score_d = high_q;
      ST_PLAY:   o_score_d = score_q;
      ST_FLASH:  o_score_d = score_q;
      ST_REVIEW: o_score_d = (HIGH_EN && alt_q) ? high_q
                                                : score_q;
      default:   o_score_d = score_q;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q   <= ST_IDLE;
      score_q   <= '0;
      cnt_q     <= '0;
      ph_q      <= '0;
      blank_q   <= 1'b0;
      alt_q     <= 1'b0;
      o_score_q <= '0;
      o_blank_q <= 1'b0;
      o_high_q  <= '0;
      o_state_q <= ST_IDLE;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      blank_q   <= blank_d;
      alt_q     <= alt_d;
      o_score_q <= o_score_d;
      o_blank_q <= blank_q;
      o_high_q  <= high_q;
      o_state_q <= state_q;
    end
  end

`ifdef SCORE_HIGH_EN
  logic [7:0] high_d;

  always_comb begin
    high_d = high_q;
    if (state_q == ST_PLAY && state_d == ST_FLASH
        && score_d > high_q)
      high_d = score_d;
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) high_q <= '0;
    else          high_q <= high_d;
  end
`else
  assign high_q = 8'h00;
`endif

  assign O_score = o_score_q;
  assign O_blank = o_blank_q;
  assign O_high  = o_high_q;
  assign O_state = o_state_q;

endmodule
